bus_slave_regbank: RTL and testbench
====================================

// Module: bus_slave_regbank
// PURPOSE
//  Bus responder at the far end of the CPU core's initiator port (ADDR_BUS/DATA_WBUS/BUS_VALID/SLAVE_READY).
//  Decodes a word-aligned address window, holds NUM_WORDS 32-bit storage words and returns read data.
//  Inserts WAIT_CYCLES programmable wait states and flags out-of-window or misaligned accesses.
//  Sits on the system bus beside ROM, as the first read/write data memory for the core.
// PARAMETERS
//  BASE_ADDR    32'h0000_1000  byte address of word 0; must be NUM_WORDS*4 aligned
//  NUM_WORDS    16             storage depth in 32-bit words; power of two, 2..256
//  WAIT_CYCLES  0              extra cycles between request accept and SLAVE_READY, 0..15
// PORTS
//  clk          in   1   single system clock; all state changes on rising edge
//  rst          in   1   synchronous, active-high reset
//  ADDR_BUS     in   32  byte address from initiator; stable while BUS_VALID high
//  DATA_WBUS    in   32  write data; stable while BUS_VALID high
//  BUS_WE       in   1   1 = write, 0 = read; stable while BUS_VALID high
//  BUS_VALID    in   1   initiator request; held until the cycle SLAVE_READY is seen high
//  SLAVE_READY  out  1   registered; high exactly one cycle per completed transfer
//  DATA_RBUS    out  32  registered read data; valid only while SLAVE_READY=1 and access was a read
//  BUS_ERR      out  1   registered; qualifies SLAVE_READY: 1 = decode error, no storage effect
// BEHAVIOUR
//  Reset (rst=1 at an edge): state IDLE, wait counter 0, SLAVE_READY=0, DATA_RBUS=0, BUS_ERR=0,
//    all storage words cleared to 0. Reset wins over every other event, including mid-transfer.
//  FSM states:
//    IDLE -> WAIT when BUS_VALID=1 and WAIT_CYCLES>0 (counter loads WAIT_CYCLES-1).
//    IDLE -> RESP when BUS_VALID=1 and WAIT_CYCLES=0.
//    WAIT -> RESP when counter=0; otherwise decrement.
//    WAIT -> IDLE when BUS_VALID drops: abort; no write, no READY.
//    RESP -> IDLE unconditionally; SLAVE_READY=1 for exactly this cycle.
//  Latency: request sampled at edge N in IDLE; SLAVE_READY high during cycle N+1+WAIT_CYCLES.
//  Completion: the transfer completes at the edge where BUS_VALID=1 and SLAVE_READY=1.
//    Write data is committed to storage at that edge.
//  Back-to-back: the initiator may hold BUS_VALID high with a new address after completion.
//    The slave is in IDLE the next cycle and samples the new request there.
//    Minimum transfer period is WAIT_CYCLES+2 cycles.
//  Decode: hit = ADDR_BUS[1:0]==0 and BASE_ADDR <= ADDR_BUS < BASE_ADDR+4*NUM_WORDS.
//    Word index = (ADDR_BUS-BASE_ADDR)>>2, width $clog2(NUM_WORDS).
//    Miss = BUS_ERR=1 with SLAVE_READY, DATA_RBUS=0, storage untouched (no hang on bad address).
//  Read: DATA_RBUS is loaded with storage[index] on entry to RESP and returns to 0 on leaving RESP.
//    A read in RESP observes every write committed before that cycle.
//  Write response: DATA_RBUS=0, BUS_ERR=0 on a hit.
//  Address, data and WE are sampled combinationally from the bus during RESP.
//    Protocol requires them stable, so the slave does not capture them at accept.
//  BUS_VALID low in IDLE or RESP: no effect. BUS_VALID low during RESP: no write is committed.
// STRUCTURE
//  Shared package bus_pkg: BUS_AW/BUS_DW=32 constants, slave FSM state enum
//    (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and a decode-hit function, all reused by future bus slaves.
//  Sub-module bus_wait_counter: 4-bit loadable down-counter with load/dec/zero ports.
//  Storage: flat reg array inside this module; one write port, one read port.
// TESTING
//  1 Reset, WAIT_CYCLES=0: write 32'hDEAD_BEEF to 32'h1004, then read 32'h1004
//    -> READY one cycle after each accept, read returns DEAD_BEEF, BUS_ERR=0.
//  2 WAIT_CYCLES=3: read 32'h1000 accepted at edge N
//    -> SLAVE_READY high only during cycle N+4, DATA_RBUS=0 (reset value).
//  3 Back-to-back writes with BUS_VALID held high to 32'h1000..32'h103C, values 0..15, then read all
//    -> each read returns its index; one READY pulse per transfer.
//  4 Access 32'h0FFC, 32'h1040 and 32'h1002
//    -> READY with BUS_ERR=1, DATA_RBUS=0; a follow-up read shows storage unchanged.
//  5 WAIT_CYCLES=3: drop BUS_VALID after 1 wait cycle of a write
//    -> no READY, storage unchanged, next request serviced normally.
//  6 Assert rst during WAIT of a write
//    -> READY stays 0, next cycle in IDLE, all words read back as 0.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus constants, slave FSM states and address decode
package bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } slave_state_t;

  // Window compare is done one bit wider so a window ending at 4 GiB does not wrap.
  function automatic logic decode_hit(input logic [BUS_AW-1:0] addr,
                                      input logic [BUS_AW-1:0] base,
                                      input int unsigned       num_words);
    logic [BUS_AW:0] a;
    logic [BUS_AW:0] lo;
    logic [BUS_AW:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + ({1'b0, BUS_AW'(num_words)} << 2);
    return (addr[1:0] == 2'b00) && (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// rtl/bus_wait_counter.sv - 4-bit loadable down-counter for slave wait states
module bus_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/bus_slave_regbank.sv
// rtl/bus_slave_regbank.sv - word-addressed register bank slave with wait states and decode error
module bus_slave_regbank
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          NUM_WORDS   = 16,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ADDR_BUS,
  input  logic [31:0] DATA_WBUS,
  input  logic        BUS_WE,
  input  logic        BUS_VALID,
  output logic        SLAVE_READY,
  output logic [31:0] DATA_RBUS,
  output logic        BUS_ERR
);

  localparam int         IW        = $clog2(NUM_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  slave_state_t state;
  slave_state_t next_state;

  logic [31:0]   mem [NUM_WORDS];
  logic          hit;
  logic [IW-1:0] idx;
  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_zero;

  // The bus is required stable for the whole request, so decode runs straight off it.
  assign hit = decode_hit(ADDR_BUS, BASE_ADDR, NUM_WORDS);
  assign idx = IW'((ADDR_BUS - BASE_ADDR) >> 2);

  bus_wait_counter u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (WAIT_LOAD),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (BUS_VALID) begin
          if (WAIT_CYCLES > 0) begin
            next_state = WAIT;
            cnt_load   = 1'b1;
          end else begin
            next_state = RESP;
          end
        end
      end
      WAIT: begin
        if (!BUS_VALID) begin
          next_state = IDLE;
        end else if (cnt_zero) begin
          next_state = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      SLAVE_READY <= 1'b0;
      DATA_RBUS   <= '0;
      BUS_ERR     <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state       <= next_state;
      SLAVE_READY <= (next_state == RESP);
      BUS_ERR     <= (next_state == RESP) && !hit;
      DATA_RBUS   <= ((next_state == RESP) && hit && !BUS_WE) ? mem[idx] : '0;
      // Writes land only at the handshake edge, so an aborted request never touches storage.
      if (SLAVE_READY && BUS_VALID && BUS_WE && hit) begin
        mem[idx] <= DATA_WBUS;
      end
    end
  end

endmodule

// File: tb/tb_bus_slave_regbank.sv
// tb/tb_bus_slave_regbank.sv - self-checking bench for bus_slave_regbank
module tb_bus_slave_regbank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        valid0;
  logic        valid3;
  logic        rdy0;
  logic        rdy3;
  logic        err0;
  logic        err3;
  logic [31:0] rd0;
  logic [31:0] rd3;

  bus_slave_regbank #(.BASE_ADDR(32'h0000_1000), .NUM_WORDS(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ADDR_BUS(addr), .DATA_WBUS(wdata), .BUS_WE(we),
    .BUS_VALID(valid0), .SLAVE_READY(rdy0), .DATA_RBUS(rd0), .BUS_ERR(err0)
  );

  bus_slave_regbank #(.BASE_ADDR(32'h0000_1000), .NUM_WORDS(16), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .ADDR_BUS(addr), .DATA_WBUS(wdata), .BUS_WE(we),
    .BUS_VALID(valid3), .SLAVE_READY(rdy3), .DATA_RBUS(rd3), .BUS_ERR(err3)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [2][16];

  function automatic bit ref_hit(input logic [31:0] a);
    return (a % 4 == 0) && (a >= 32'h1000) && (a < 32'h1000 + 16 * 4);
  endfunction

  function automatic logic [31:0] obs_rdy(input int sel);
    return sel != 0 ? 32'(rdy3) : 32'(rdy0);
  endfunction

  function automatic logic [31:0] obs_err(input int sel);
    return sel != 0 ? 32'(err3) : 32'(err0);
  endfunction

  function automatic logic [31:0] obs_rd(input int sel);
    return sel != 0 ? rd3 : rd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input int sel, input logic v);
    if (sel != 0) valid3 = v;
    else valid0 = v;
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        model[s][i] = 32'h0;
  endtask

  // Starts and ends just after a falling edge; sel 0 = zero-wait slave, 1 = three-wait slave.
  task automatic xfer(input int sel, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input bit hold, input string tag);
    int          wc;
    bit          h;
    int          idx;
    logic [31:0] exp_rd;
    wc     = (sel != 0) ? 3 : 0;
    h      = ref_hit(a);
    idx    = int'((a - 32'h1000) / 4);
    exp_rd = (h && !w) ? model[sel][idx] : 32'h0;
    addr   = a;
    wdata  = d;
    we     = w;
    set_valid(sel, 1'b1);
    for (int k = 1; k <= wc + 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s ready cyc%0d", tag, k), obs_rdy(sel), 32'(k == wc + 1));
    end
    check($sformatf("%s err", tag), obs_err(sel), 32'(!h));
    check($sformatf("%s rdata", tag), obs_rd(sel), exp_rd);
    @(posedge clk);
    if (w && h) model[sel][idx] = d;
    @(negedge clk);
    if (!hold) set_valid(sel, 1'b0);
    check($sformatf("%s ready after", tag), obs_rdy(sel), 32'h0);
    check($sformatf("%s rdata after", tag), obs_rd(sel), 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    int          r;
    rst    = 1'b1;
    addr   = 32'h0;
    wdata  = 32'h0;
    we     = 1'b0;
    valid0 = 1'b0;
    valid3 = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready0", 32'(rdy0), 32'h0);
    check("reset err0", 32'(err0), 32'h0);
    check("reset rdata0", rd0, 32'h0);
    check("reset ready3", 32'(rdy3), 32'h0);
    check("reset rdata3", rd3, 32'h0);
    rst = 1'b0;

    xfer(0, 1'b1, 32'h1004, 32'hDEAD_BEEF, 1'b0, "t1 wr");
    xfer(0, 1'b0, 32'h1004, 32'h0, 1'b0, "t1 rd");
    check("t1 model word1", model[0][1], 32'hDEAD_BEEF);

    xfer(1, 1'b0, 32'h1000, 32'h0, 1'b0, "t2 rd wait3");

    for (int i = 0; i < 16; i++)
      xfer(0, 1'b1, 32'h1000 + 32'(4 * i), 32'(i), i < 15, $sformatf("t3 wr%0d", i));
    for (int i = 0; i < 16; i++)
      xfer(0, 1'b0, 32'h1000 + 32'(4 * i), 32'h0, i < 15, $sformatf("t3 rd%0d", i));

    xfer(0, 1'b0, 32'h0FFC, 32'h0, 1'b0, "t4 rd low");
    xfer(0, 1'b1, 32'h0FFC, 32'h1111_1111, 1'b0, "t4 wr low");
    xfer(0, 1'b1, 32'h1040, 32'h2222_2222, 1'b0, "t4 wr high");
    xfer(0, 1'b0, 32'h1040, 32'h0, 1'b0, "t4 rd high");
    xfer(0, 1'b1, 32'h1002, 32'h3333_3333, 1'b0, "t4 wr misal");
    xfer(0, 1'b0, 32'h1002, 32'h0, 1'b0, "t4 rd misal");
    xfer(0, 1'b0, 32'h1000, 32'h0, 1'b0, "t4 rd word0");
    xfer(0, 1'b0, 32'h103C, 32'h0, 1'b0, "t4 rd word15");

    xfer(1, 1'b1, 32'h1010, 32'hA5A5_0001, 1'b0, "t5 pre wr");
    addr  = 32'h1010;
    wdata = 32'h5555_AAAA;
    we    = 1'b1;
    valid3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5 ready during wait", 32'(rdy3), 32'h0);
    @(posedge clk);
    @(negedge clk);
    valid3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("t5 no ready %0d", k), 32'(rdy3), 32'h0);
    end
    xfer(1, 1'b0, 32'h1010, 32'h0, 1'b0, "t5 rd unchanged");
    xfer(1, 1'b1, 32'h1014, 32'h0BAD_CAFE, 1'b0, "t5 next wr");
    xfer(1, 1'b0, 32'h1014, 32'h0, 1'b0, "t5 next rd");

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 40; i++) begin
        r = int'($urandom_range(0, 9));
        if (r < 7)       ra = 32'h1000 + 32'(4 * $urandom_range(0, 15));
        else if (r == 7) ra = 32'h1000 + 32'($urandom_range(0, 63));
        else if (r == 8) ra = 32'h0FF0 + 32'(4 * $urandom_range(0, 3));
        else             ra = 32'h1040 + 32'(4 * $urandom_range(0, 7));
        xfer(s, 1'($urandom_range(0, 1)), ra, $urandom, (i < 39) && ($urandom_range(0, 1) == 1),
             $sformatf("rnd s%0d i%0d", s, i));
      end
    end

    addr   = 32'h1008;
    wdata  = 32'hFFFF_0000;
    we     = 1'b1;
    valid3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("t6 ready in wait", 32'(rdy3), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    valid3 = 1'b0;
    clear_model();
    check("t6 ready after rst", 32'(rdy3), 32'h0);
    check("t6 rdata after rst", rd3, 32'h0);
    check("t6 err after rst", 32'(err3), 32'h0);
    for (int i = 0; i < 16; i++)
      xfer(1, 1'b0, 32'h1000 + 32'(4 * i), 32'h0, 1'b0, $sformatf("t6 rd%0d", i));
    xfer(0, 1'b0, 32'h1004, 32'h0, 1'b0, "t6 rd dut0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
